// File: rtl/mux_nc_arb.sv
// N-channel registered mux with valid/ready handshakes: fixed select (mode 0)
// or round-robin arbitration (mode 1); one-cycle latency, no drain bubble.

module mux_nc_lane #(
  parameter int W   = 8,
  parameter int SW  = 2,
  parameter int IDX = 0
) (
  input  logic          gnt_vld,
  input  logic [SW-1:0] gnt,
  input  logic          space,
  input  logic [W-1:0]  data,
  output logic          rdy,
  output logic [W-1:0]  data_m
);
  logic hit;

  assign hit    = gnt_vld && (gnt == SW'(IDX));
  assign rdy    = hit && space;
  assign data_m = hit ? data : '0;
endmodule

module mux_nc_arb #(
  parameter int N  = 4,
  parameter int W  = 8,
  parameter int SW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           mode,
  input  logic [SW-1:0]  sel,
  input  logic [N-1:0]   in_valid,
  input  logic [N*W-1:0] in_data,
  output logic [N-1:0]   in_ready,
  output logic           out_valid,
  output logic [W-1:0]   out_data,
  output logic [SW-1:0]  out_ch,
  input  logic           out_ready
);
  typedef struct packed {
    logic          vld;
    logic [SW-1:0] ch;
    logic [W-1:0]  data;
  } oreg_t;

  oreg_t                  out_q, out_d;
  logic [SW-1:0]          ptr_q, ptr_d;
  logic                   space;
  logic                   rr_found;
  logic [SW-1:0]          rr_gnt;
  logic [SW:0]            idx;
  logic                   sel_ok;
  logic                   gnt_vld;
  logic [SW-1:0]          gnt;
  logic [N-1:0][W-1:0]    data_m;
  logic [W-1:0]           data_sel;
  logic                   xfer;

  assign space = !out_q.vld || out_ready;

  // Rotating search from ptr; idx stays below 2N so one conditional subtract wraps it.
  always_comb begin
    rr_found = 1'b0;
    rr_gnt   = '0;
    idx      = '0;
    for (int k = 0; k < N; k++) begin
      idx = {1'b0, ptr_q} + (SW+1)'(k);
      if (idx >= (SW+1)'(N)) idx = idx - (SW+1)'(N);
      if (!rr_found && in_valid[idx[SW-1:0]]) begin
        rr_found = 1'b1;
        rr_gnt   = idx[SW-1:0];
      end
    end
  end

  assign sel_ok  = ({1'b0, sel} < (SW+1)'(N));
  assign gnt_vld = mode ? rr_found : sel_ok;
  assign gnt     = mode ? rr_gnt : sel;

  for (genvar i = 0; i < N; i++) begin : g_lane
    mux_nc_lane #(.W(W), .SW(SW), .IDX(i)) u_lane (
      .gnt_vld (gnt_vld),
      .gnt     (gnt),
      .space   (space),
      .data    (in_data[i*W +: W]),
      .rdy     (in_ready[i]),
      .data_m  (data_m[i])
    );
  end

  assign xfer = |(in_valid & in_ready);

  always_comb begin
    data_sel = '0;
    for (int i = 0; i < N; i++) data_sel = data_sel | data_m[i];
  end

  always_comb begin
    out_d = out_q;
    ptr_d = ptr_q;
    if (xfer) begin
      out_d.vld  = 1'b1;
      out_d.ch   = gnt;
      out_d.data = data_sel;
      if (mode) ptr_d = (gnt == SW'(N-1)) ? '0 : gnt + SW'(1);
    end else if (out_q.vld && out_ready) begin
      out_d.vld = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q <= '0;
      ptr_q <= '0;
    end else begin
      out_q <= out_d;
      ptr_q <= ptr_d;
    end
  end

  assign out_valid = out_q.vld;
  assign out_data  = out_q.data;
  assign out_ch    = out_q.ch;
endmodule

// File: tb/tb_mux_nc_arb.sv
// Directed bench for mux_nc_arb at N=4 and N=3; expected words go through a scoreboard queue.

module tb_mux_nc_arb;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n4, mode4, out_ready4, out_valid4;
  logic [1:0]  sel4, out_ch4;
  logic [3:0]  in_valid4, in_ready4;
  logic [31:0] in_data4;
  logic [7:0]  out_data4;

  logic        rst_n3, mode3, out_ready3, out_valid3;
  logic [1:0]  sel3, out_ch3;
  logic [2:0]  in_valid3, in_ready3;
  logic [23:0] in_data3;
  logic [7:0]  out_data3;

  mux_nc_arb #(.N(4), .W(8)) u4 (
    .clk(clk), .rst_n(rst_n4), .mode(mode4), .sel(sel4),
    .in_valid(in_valid4), .in_data(in_data4), .in_ready(in_ready4),
    .out_valid(out_valid4), .out_data(out_data4), .out_ch(out_ch4),
    .out_ready(out_ready4)
  );

  mux_nc_arb #(.N(3), .W(8)) u3 (
    .clk(clk), .rst_n(rst_n3), .mode(mode3), .sel(sel3),
    .in_valid(in_valid3), .in_data(in_data3), .in_ready(in_ready3),
    .out_valid(out_valid3), .out_data(out_data3), .out_ch(out_ch3),
    .out_ready(out_ready3)
  );

  typedef struct {
    logic [7:0] data;
    logic [1:0] ch;
  } exp_t;

  exp_t       sb[$];
  exp_t       last;
  int         errors = 0;
  int         checks = 0;
  logic [3:0] s = 4'd0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] d, input logic [1:0] c);
    exp_t e;
    e.data = d;
    e.ch   = c;
    sb.push_back(e);
  endtask

  task automatic pop_chk(input string tag, input logic v, input logic [7:0] d, input logic [1:0] c);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: observed word %0h with empty scoreboard, expected none", tag, d);
      return;
    end
    e    = sb.pop_front();
    last = e;
    chk({tag, ".valid"}, v, 1);
    chk({tag, ".data"}, d, e.data);
    chk({tag, ".ch"}, c, e.ch);
  endtask

  function automatic logic [31:0] dpat4(input logic [3:0] t);
    return {4'd3, t, 4'd2, t, 4'd1, t, 4'd0, t};
  endfunction

  function automatic logic [23:0] dpat3(input logic [3:0] t);
    return {4'd2, t, 4'd1, t, 4'd0, t};
  endfunction

  // One cycle on u4: fresh data, check in_ready, expect a word from exp_ch (-1 = none).
  task automatic step4(input string tag, input logic [3:0] exp_rdy, input int exp_ch);
    s++;
    in_data4 = dpat4(s);
    #1;
    chk({tag, ".rdy"}, in_ready4, exp_rdy);
    if (exp_ch >= 0) push({2'b00, exp_ch[1:0], s}, exp_ch[1:0]);
    tick();
    if (exp_ch >= 0) pop_chk(tag, out_valid4, out_data4, out_ch4);
  endtask

  task automatic step3(input string tag, input logic [2:0] exp_rdy, input int exp_ch);
    s++;
    in_data3 = dpat3(s);
    #1;
    chk({tag, ".rdy"}, in_ready3, exp_rdy);
    if (exp_ch >= 0) push({2'b00, exp_ch[1:0], s}, exp_ch[1:0]);
    tick();
    if (exp_ch >= 0) pop_chk(tag, out_valid3, out_data3, out_ch3);
  endtask

  task automatic randomize_inputs();
    mode4 = 1'($urandom_range(1)); sel4 = 2'($urandom_range(3));
    in_valid4 = 4'($urandom_range(15)); in_data4 = $urandom; out_ready4 = 1'($urandom_range(1));
    mode3 = 1'($urandom_range(1)); sel3 = 2'($urandom_range(3));
    in_valid3 = 3'($urandom_range(7)); in_data3 = 24'($urandom); out_ready3 = 1'($urandom_range(1));
  endtask

  initial begin
    rst_n4 = 1'b0;
    rst_n3 = 1'b0;
    randomize_inputs();
    repeat (2) begin
      tick();
      chk("rst4.valid", out_valid4, 0);
      chk("rst4.data", out_data4, 0);
      chk("rst4.ch", out_ch4, 0);
      chk("rst3.valid", out_valid3, 0);
      randomize_inputs();
    end

    rst_n4 = 1'b1; mode4 = 1'b1; in_valid4 = 4'hF; out_ready4 = 1'b1;
    rst_n3 = 1'b1; mode3 = 1'b0; sel3 = 2'd3; in_valid3 = 3'b111; out_ready3 = 1'b1;

    // Fairness: all valid cycles 0..3, first grant after reset is channel 0.
    step4("fair0", 4'b0001, 0);
    step4("fair1", 4'b0010, 1);
    step4("fair2", 4'b0100, 2);
    step4("fair3", 4'b1000, 3);

    in_valid4 = 4'b1011;
    for (int r = 0; r < 2; r++) begin
      step4("rr_a", 4'b0001, 0);
      step4("rr_b", 4'b0010, 1);
      step4("rr_c", 4'b1000, 3);
    end
    in_valid4 = 4'hF;
    step4("rr_ptr1", 4'b0001, 0);

    // Fixed select; pointer stays at 1 while in mode 0.
    mode4 = 1'b0; sel4 = 2'd2;
    in_data4 = dpat4(s); in_data4[23:16] = 8'hA5;
    #1; chk("sel2.rdy", in_ready4, 4'b0100);
    push(8'hA5, 2'd2);
    tick(); pop_chk("sel2", out_valid4, out_data4, out_ch4);
    sel4 = 2'd3; in_data4[31:24] = 8'h3C;
    #1; chk("sel3.rdy", in_ready4, 4'b1000);
    push(8'h3C, 2'd3);
    tick(); pop_chk("sel3", out_valid4, out_data4, out_ch4);

    // Back-pressure for 3 cycles, then drain and reload in the same edge.
    mode4 = 1'b1; out_ready4 = 1'b0;
    repeat (3) begin
      #1; chk("bp.rdy", in_ready4, 4'b0000);
      tick();
      chk("bp.valid", out_valid4, 1);
      chk("bp.data", out_data4, last.data);
      chk("bp.ch", out_ch4, last.ch);
    end
    out_ready4 = 1'b1;
    step4("bp_rel", 4'b0010, 1);
    step4("bp_next", 4'b0100, 2);

    in_valid4 = 4'b0000;
    step4("drain", 4'b0000, -1);
    chk("drain.valid", out_valid4, 0);
    chk("drain.data", out_data4, last.data);
    chk("drain.ch", out_ch4, last.ch);

    mode4 = 1'b0; sel4 = 2'd1; in_valid4 = 4'b1101;
    step4("sel_novalid", 4'b0010, -1);
    chk("sel_novalid.valid", out_valid4, 0);

    // N=3: out-of-range select, then reset mid-stream in round-robin.
    step3("oor", 3'b000, -1);
    chk("oor.valid", out_valid3, 0);
    sel3 = 2'd2;
    step3("n3_sel2", 3'b100, 2);
    mode3 = 1'b1;
    step3("n3_rr0", 3'b001, 0);
    step3("n3_rr1", 3'b010, 1);
    rst_n3 = 1'b0;
    s++; in_data3 = dpat3(s);
    #1; chk("n3_rst.rdy", in_ready3, 3'b100);
    tick();
    chk("n3_rst.valid", out_valid3, 0);
    chk("n3_rst.data", out_data3, 0);
    chk("n3_rst.ch", out_ch3, 0);
    rst_n3 = 1'b1;
    step3("n3_after_rst", 3'b001, 0);

    chk("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mux_nc_arb.md
# mux_nc_arb

Parametrised N-channel, W-bit multiplexer with a registered output and valid/ready handshakes on every channel. It has two modes: external select (the generalised `mux21c` behaviour) and fair round-robin arbitration across channels. It sits between several streaming producers and a single consumer, and gives one-cycle latency with full throughput under continuous back-pressure-free flow.

## Interface
Parameters:
- `N`, 4, number of input channels; must be ≥ 2, need not be a power of two
- `W`, 8, data width in bits
- `SW`, `$clog2(N)`, width of the select and channel-id fields; derived, not overridden

Ports:
- `clk`  in  1  clock; all state updates on the rising edge
- `rst_n`  in  1  synchronous, active-low reset, sampled on the rising edge of `clk`
- `mode`  in  1  0 = fixed select via `sel`, 1 = round-robin
- `sel`  in  SW  channel index used when `mode`=0
- `in_valid`  in  N  per-channel valid; bit i belongs to channel i
- `in_data`  in  N*W  channel i occupies bits [i*W +: W]
- `in_ready`  out  N  per-channel ready; at most one bit is high in any cycle
- `out_valid`  out  1  output register holds a word
- `out_data`  out  W  registered data
- `out_ch`  out  SW  index of the channel that supplied `out_data`
- `out_ready`  in  1  consumer accepts the word when `out_valid`=1

## Operation
- State: output register (`out_valid`, `out_data`, `out_ch`) and a round-robin pointer `ptr` (SW bits).
- Space: `space = !out_valid || out_ready`.
- Grant `g`, combinational, evaluated every cycle:
  - `mode`=0: `g = sel`, regardless of `in_valid`. If `sel >= N`, there is no grant.
  - `mode`=1: `g` is the first channel with `in_valid` set, searching from `ptr` upward and wrapping modulo N. If no channel is valid, there is no grant.
- Ready: `in_ready[g] = space`. All other bits are 0, and all bits are 0 when there is no grant. In mode 0, `in_ready[sel]` may be high while `in_valid[sel]` is low.
- Transfer on channel g: `in_valid[g] && in_ready[g]`.
  - On the next edge, `out_data` ← channel g data, `out_ch` ← g, and `out_valid` ← 1.
  - In mode 1 only, `ptr` ← (g+1) mod N.
- Drain without a new transfer: when `out_valid && out_ready` and no transfer occurs, `out_valid` ← 0. `out_data` and `out_ch` hold their values.
- Simultaneous drain and transfer: the register reloads in the same edge and `out_valid` stays 1. There is no bubble.
- Stall: when `out_valid && !out_ready`, the output register is frozen, all `in_ready` bits are 0, and `ptr` is frozen.
- Mode changes take effect combinationally. `ptr` is retained across mode 0 periods; mode 0 never modifies it.
- Producers must hold `in_data` stable while valid and not accepted. The block does not check this.

## Timing
- Reset (`rst_n`=0 at an edge): `out_valid`=0, `out_data`=0, `out_ch`=0, `ptr`=0.
  - During reset, `in_ready` follows the combinational rules using the reset state, so some channel may show ready. Transfers in a reset cycle are discarded; reset has priority.
- Reset mid-stream: a word held in the register is dropped and `out_valid` falls at that edge.
- Latency: data accepted at edge k appears on `out_data` with `out_valid`=1 after edge k, i.e. one cycle.
- Throughput: one word per cycle while `out_ready`=1 and the granted channel is valid.
- `in_ready` depends combinationally on `out_ready`, `mode`, `sel`, `in_valid` and `ptr`. There is no combinational path from `in_data` to any output.
- Fairness (mode 1): with all N channels continuously valid and `out_ready`=1, grants cycle 0,1,…,N-1,0,… and each channel gets exactly one grant per N cycles.

## Test plan
- **Reset values:** assert `rst_n`=0 for 2 cycles with random inputs → `out_valid`=0, `out_data`=0, `out_ch`=0. The first RR grant after release, with all channels valid, goes to channel 0.
- **Fixed select (N=4, W=8):** `mode`=0, `sel`=2, `in_valid`=4'b1111, channel 2 data=8'hA5 → `in_ready`=4'b0100 and the next cycle gives `out_data`=8'hA5, `out_ch`=2. Set `sel`=3 (channel 3 data=8'h3C) → `out_data`=8'h3C, `out_ch`=3 one cycle later.
- **Round-robin:** `mode`=1, `in_valid`=4'b1011, `out_ready`=1 → `out_ch` sequence 0,1,3,0,1,3. Channel 2 never appears.
- **Back-pressure:** hold `out_ready`=0 for 3 cycles while `out_valid`=1 → `in_ready`=0, and `out_data`, `out_ch` and `ptr` are unchanged. On release, the held word drains and the next word loads in the same edge with no bubble.
- **Out-of-range and reset mid-stream (N=3):** `mode`=0, `sel`=3 → `in_ready`=3'b000. Then in mode 1, pulse `rst_n`=0 while `out_valid`=1 → `out_valid`=0 at the next edge and `ptr` returns to 0.
